iq_demod_decim: RTL
===================

IQ_DEMOD_DECIM -- requirements
Module: iq_demod_decim

Interface
REQ-001 Parameter IN_W, 8, signed input sample width.
REQ-002 Parameter OUT_W, 16, signed I/Q output width.
REQ-003 Parameter NCO_W, 32, phase accumulator width.
REQ-004 Parameter LUT_AW, 10, phase bits addressing sine table (2^LUT_AW entries, 12-bit signed amplitude).
REQ-005 Parameter CNT_W, 10, decimation counter width.
REQ-006 Parameter ACC_SHIFT, 10, arithmetic right shift applied to integrator sum before output.
REQ-007 clk_in  input  1  clock; all logic on rising edge.
REQ-008 RST  input  1  synchronous, active-high reset.
REQ-009 lo_fre  input  NCO_W  LO frequency word, unsigned.
REQ-010 lo_pha  input  NCO_W  LO phase offset word, unsigned.
REQ-011 dec_n  input  CNT_W  decimation ratio; 0 and 1 both mean 1.
REQ-012 in_valid  input  1  data_in qualifier.
REQ-013 data_in  input  IN_W  signed sample.
REQ-014 out_valid  output  1  one-cycle pulse marking valid I_OUT/Q_OUT.
REQ-015 I_OUT  output  OUT_W  signed in-phase result, held between pulses.
REQ-016 Q_OUT  output  OUT_W  signed quadrature result, held between pulses.
REQ-017 ovf  output  1  sticky saturation flag.

Function
REQ-018 Phase accumulator SHALL add lo_fre only in cycles with in_valid=1; wraps modulo 2^NCO_W.
REQ-019 Sine address SHALL be top LUT_AW bits of (acc+lo_pha); cosine address SHALL be top LUT_AW bits of (acc+lo_pha+2^(NCO_W-2)); both table reads registered (1 cycle).
REQ-020 I product = sample*cos, Q product = sample*sin, full IN_W+12 bits signed, registered (1 cycle); input sample delayed to align with its own phase.
REQ-021 Integrators SHALL be IN_W+12+CNT_W bits, accumulating aligned products; no internal wrap possible.
REQ-022 On the dec_n-th accumulated product, sum (including that product) SHALL be shifted right arithmetically by ACC_SHIFT, saturated to OUT_W, registered to I_OUT/Q_OUT; integrator restarts from next product (dump, no carry-over).
REQ-023 out_valid SHALL pulse 3 cycles after the in_valid cycle of the block's last sample (DC block disabled).
REQ-024 dec_n SHALL be sampled at block start; changes mid-block take effect at next block.
REQ-025 Saturation on either channel SHALL set ovf; ovf cleared only by RST.
REQ-026 in_valid gaps SHALL stall the pipeline contents' accounting only; a sample is never lost or duplicated; back-to-back in_valid sustains one sample/cycle.
REQ-027 Max positive saturates to 2^(OUT_W-1)-1, max negative to -2^(OUT_W-1).

Reset
REQ-028 RST SHALL zero phase accumulator, pipeline registers, integrators, sample counter, I_OUT, Q_OUT, out_valid, ovf.
REQ-029 RST mid-block SHALL discard partial sums; first block after reset starts with first in_valid sample after RST deasserts.
REQ-030 In-flight samples during RST SHALL produce no out_valid.

Configuration
REQ-031 Macro IQ_DEMOD_DCBLK_EN defined: input passes through registered DC blocker y[n]=x[n]-x[n-1]+y[n-1]-(y[n-1]>>>8), IN_W+8 bits internal, rounded back to IN_W, adding 1 cycle (out_valid latency 4).
REQ-032 Macro undefined: no DC blocker, latency per REQ-023, no blocker registers synthesised.

Verification
REQ-033 lo_fre=0, lo_pha=0, data_in=+100 constant, dec_n=1, ACC_SHIFT=0 -> I_OUT≈100*2047, Q_OUT=0 after 3 cycles, then per cycle (OUT_W=24 build).
REQ-034 lo_fre=2^30, dec_n=4, data_in = cosine at fs/4, amplitude 100 -> I constant positive, Q≈0, out_valid every 4th sample.
REQ-035 dec_n changed 4->8 mid-block -> current block ends at 4, next spans 8; no pulse lost.
REQ-036 data_in=+127, lo_fre=0, dec_n=1023, ACC_SHIFT=0, OUT_W=16 -> I_OUT=32767, ovf=1 until RST.
REQ-037 RST asserted after 2 of 4 samples -> all outputs 0, next out_valid exactly after 4 fresh samples.
REQ-038 IQ_DEMOD_DCBLK_EN defined, constant data_in=50 -> I/Q decay toward 0; out_valid latency 4.

Source files
------------

// File: rtl/iq_demod_decim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iq_demod_decim                                             |
// | Description : NCO-based I/Q down-converter with integrate-and-dump       |
// |               decimation, arithmetic output scaling and saturation.      |
// |               Optional input DC blocker when IQ_DEMOD_DCBLK_EN is        |
// |               defined (adds one cycle of latency).                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module iq_demod_decim #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int NCO_W     = 32,
  parameter int LUT_AW    = 10,
  parameter int CNT_W     = 10,
  parameter int ACC_SHIFT = 10
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic [NCO_W-1:0]        lo_fre,
  input  logic [NCO_W-1:0]        lo_pha,
  input  logic [CNT_W-1:0]        dec_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] I_OUT,
  output logic signed [OUT_W-1:0] Q_OUT,
  output logic                    ovf
);

  localparam int  c_LUT_N  = 1 << LUT_AW;
  localparam int  c_PROD_W = IN_W + 12;
  localparam int  c_INT_W  = c_PROD_W + CNT_W;
  localparam real c_PI     = 3.14159265358979323846;
  localparam logic [NCO_W-1:0] c_QTR = {2'b01, {(NCO_W-2){1'b0}}};
  localparam logic signed [c_INT_W-1:0] c_MAX = {{(c_INT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [c_INT_W-1:0] c_MIN = {{(c_INT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Sine table, amplitude 2047, built at elaboration time
  logic signed [11:0] w_lut [c_LUT_N];
  for (genvar k = 0; k < c_LUT_N; k++) begin : g_lut
    localparam real c_ANG = 2.0 * c_PI * k / c_LUT_N;
    localparam int  c_VAL = int'($floor(2047.0 * $sin(c_ANG) + 0.5));
    assign w_lut[k] = c_VAL[11:0];
  end

  // Front-end sample stream feeding the mixer (raw or DC-blocked)
  logic                   w_s_v;
  logic signed [IN_W-1:0] w_s_d;

`ifdef IQ_DEMOD_DCBLK_EN
  // Blocker state keeps 8 fractional bits; 2 guard bits catch the sum overflow
  localparam int c_DC_W  = IN_W + 8;
  localparam int c_DCX_W = IN_W + 10;
  localparam logic signed [c_DCX_W-1:0] c_DC_MAX = {{3{1'b0}}, {(c_DC_W-1){1'b1}}};
  localparam logic signed [c_DCX_W-1:0] c_DC_MIN = {{3{1'b1}}, {(c_DC_W-1){1'b0}}};
  localparam logic signed [c_DCX_W-1:0] c_IN_MAX = {{(c_DCX_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [c_DCX_W-1:0] c_IN_MIN = {{(c_DCX_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  logic signed [IN_W-1:0]    r_dc_x;
  logic signed [IN_W-1:0]    r_dc_out;
  logic signed [c_DC_W-1:0]  r_dc_y;
  logic                      r_dc_v;
  logic signed [c_DCX_W-1:0] w_dc_sum;
  logic signed [c_DCX_W-1:0] w_dc_ysat;
  logic signed [c_DCX_W-1:0] w_dc_rnd;
  logic signed [c_DC_W-1:0]  w_dc_ynew;
  logic signed [IN_W-1:0]    w_dc_q;

  // y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), then round back to IN_W
  always_comb begin
    w_dc_sum = c_DCX_W'($signed({data_in, 8'd0})) - c_DCX_W'($signed({r_dc_x, 8'd0}))
             + c_DCX_W'(r_dc_y) - c_DCX_W'(r_dc_y >>> 8);
    if (w_dc_sum > c_DC_MAX)      w_dc_ysat = c_DC_MAX;
    else if (w_dc_sum < c_DC_MIN) w_dc_ysat = c_DC_MIN;
    else                          w_dc_ysat = w_dc_sum;
    w_dc_ynew = w_dc_ysat[c_DC_W-1:0];
    w_dc_rnd  = (w_dc_ysat + c_DCX_W'(128)) >>> 8;
    if (w_dc_rnd > c_IN_MAX)      w_dc_q = c_IN_MAX[IN_W-1:0];
    else if (w_dc_rnd < c_IN_MIN) w_dc_q = c_IN_MIN[IN_W-1:0];
    else                          w_dc_q = w_dc_rnd[IN_W-1:0];
  end

  // Blocker state advances only on qualified samples
  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_dc_x   <= '0;
      r_dc_y   <= '0;
      r_dc_out <= '0;
      r_dc_v   <= 1'b0;
    end else begin
      r_dc_v <= in_valid;
      if (in_valid) begin
        r_dc_x   <= data_in;
        r_dc_y   <= w_dc_ynew;
        r_dc_out <= w_dc_q;
      end
    end
  end

  assign w_s_v = r_dc_v;
  assign w_s_d = r_dc_out;
`else
  assign w_s_v = in_valid;
  assign w_s_d = data_in;
`endif

  // Phase generation and block bookkeeping
  logic [NCO_W-1:0] r_acc;
  logic [NCO_W-1:0] w_ph_s;
  logic [NCO_W-1:0] w_ph_c;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_len;
  logic             w_last;

  assign w_ph_s = r_acc + lo_pha;
  assign w_ph_c = w_ph_s + c_QTR;

  // Block length latched from dec_n on the first sample of each block
  always_comb begin
    w_len = r_len;
    if (r_cnt == '0) w_len = (dec_n <= CNT_W'(1)) ? CNT_W'(1) : dec_n;
    w_last = ((r_cnt + CNT_W'(1)) == w_len);
  end

  // Stage 1: LUT reads, sample alignment, phase and sample-count advance
  logic                   r_v1;
  logic                   r_l1;
  logic signed [IN_W-1:0] r_smp;
  logic signed [11:0]     r_sin;
  logic signed [11:0]     r_cos;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_v1  <= 1'b0;
      r_l1  <= 1'b0;
      r_smp <= '0;
      r_sin <= '0;
      r_cos <= '0;
    end else begin
      r_v1 <= w_s_v;
      r_l1 <= w_s_v & w_last;
      if (w_s_v) begin
        r_smp <= w_s_d;
        r_sin <= w_lut[w_ph_s[NCO_W-1 -: LUT_AW]];
        r_cos <= w_lut[w_ph_c[NCO_W-1 -: LUT_AW]];
        r_acc <= r_acc + lo_fre;
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        r_len <= w_len;
      end
    end
  end

  // Stage 2: full-precision mixer products
  logic                       r_v2;
  logic                       r_l2;
  logic signed [c_PROD_W-1:0] r_pi;
  logic signed [c_PROD_W-1:0] r_pq;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_v2 <= 1'b0;
      r_l2 <= 1'b0;
      r_pi <= '0;
      r_pq <= '0;
    end else begin
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      if (r_v1) begin
        r_pi <= c_PROD_W'(r_smp) * c_PROD_W'(r_cos);
        r_pq <= c_PROD_W'(r_smp) * c_PROD_W'(r_sin);
      end
    end
  end

  // Integrate, scale and saturate; the sum includes the block's last product
  logic signed [c_INT_W-1:0] r_int_i;
  logic signed [c_INT_W-1:0] r_int_q;
  logic signed [c_INT_W-1:0] w_sum_i;
  logic signed [c_INT_W-1:0] w_sum_q;
  logic signed [c_INT_W-1:0] w_sh_i;
  logic signed [c_INT_W-1:0] w_sh_q;
  logic signed [OUT_W-1:0]   w_sat_i;
  logic signed [OUT_W-1:0]   w_sat_q;
  logic                      w_clip;

  // Saturating conversion of the scaled sums to the output width
  always_comb begin
    w_sum_i = r_int_i + c_INT_W'(r_pi);
    w_sum_q = r_int_q + c_INT_W'(r_pq);
    w_sh_i  = w_sum_i >>> ACC_SHIFT;
    w_sh_q  = w_sum_q >>> ACC_SHIFT;
    w_clip  = 1'b0;
    w_sat_i = w_sh_i[OUT_W-1:0];
    w_sat_q = w_sh_q[OUT_W-1:0];
    if (w_sh_i > c_MAX) begin
      w_sat_i = c_MAX[OUT_W-1:0];
      w_clip  = 1'b1;
    end else if (w_sh_i < c_MIN) begin
      w_sat_i = c_MIN[OUT_W-1:0];
      w_clip  = 1'b1;
    end
    if (w_sh_q > c_MAX) begin
      w_sat_q = c_MAX[OUT_W-1:0];
      w_clip  = 1'b1;
    end else if (w_sh_q < c_MIN) begin
      w_sat_q = c_MIN[OUT_W-1:0];
      w_clip  = 1'b1;
    end
  end

  // Stage 3: integrator update, dump on last product, held outputs, sticky ovf
  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_int_i   <= '0;
      r_int_q   <= '0;
      I_OUT     <= '0;
      Q_OUT     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= r_v2 & r_l2;
      if (r_v2) begin
        if (r_l2) begin
          r_int_i <= '0;
          r_int_q <= '0;
          I_OUT   <= w_sat_i;
          Q_OUT   <= w_sat_q;
          if (w_clip) ovf <= 1'b1;
        end else begin
          r_int_i <= w_sum_i;
          r_int_q <= w_sum_q;
        end
      end
    end
  end

endmodule
`default_nettype wire
